inc_loop_ctrl: RTL and testbench

Loop-index controller that sits directly upstream of the INC datapath component and consumes its result.
- Holds the current loop index in a register and drives it to INC's input `a`.
- Captures INC's output `d` as the next index.
- Terminates when the index reaches a programmed limit.
- Provides the sequential half of a counted loop (for i = init; i < limit; i++) in the scheduled datapaths the component library targets.

---
 rtl/inc_loop_ctrl_pkg.sv | 10 +
 rtl/inc_loop_ctrl_if.sv | 31 +++
 rtl/inc_loop_ctrl.sv | 63 ++++++
 tb/tb_inc_loop_ctrl.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/inc_loop_ctrl_pkg.sv
// Shared definitions for the counted-loop controllers (increment and decrement variants).
package inc_loop_ctrl_pkg;

  localparam int DEF_DATAWIDTH = 8;

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_DONE = 2'b10;

endpackage

// File: rtl/inc_loop_ctrl_if.sv
// Command, status and INC-side signals of the loop-index controller.
interface inc_loop_ctrl_if
  import inc_loop_ctrl_pkg::*;
#(
  parameter int DATAWIDTH = DEF_DATAWIDTH
);

  logic                 start;
  logic [DATAWIDTH-1:0] init;
  logic [DATAWIDTH-1:0] limit;
  logic                 hold;
  logic [DATAWIDTH-1:0] inc_a;
  logic [DATAWIDTH-1:0] inc_d;
  logic [DATAWIDTH-1:0] idx;
  logic                 valid;
  logic                 busy;
  logic                 done;
  logic                 ovf;

  // master: the parent datapath (issues the loop, hosts INC); slave: the controller
  modport master (
    output start, init, limit, hold, inc_d,
    input  inc_a, idx, valid, busy, done, ovf
  );

  modport slave (
    input  start, init, limit, hold, inc_d,
    output inc_a, idx, valid, busy, done, ovf
  );

endinterface

// File: rtl/inc_loop_ctrl.sv
// Loop-index controller: holds the index for an external INC and steps it until the limit.
//   state  | meaning
//   S_IDLE | waiting for start; outputs keep last index
//   S_RUN  | iterating; idx is live unless hold stalls
//   S_DONE | one-cycle completion pulse, then back to idle
module inc_loop_ctrl
  import inc_loop_ctrl_pkg::*;
#(
  parameter int DATAWIDTH = DEF_DATAWIDTH
) (
  input logic           clk,
  input logic           rst,
  inc_loop_ctrl_if.slave bus
);

  logic [1:0]           state;
  logic [DATAWIDTH-1:0] idx_r;
  logic [DATAWIDTH-1:0] limit_r;
  logic                 ovf_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      idx_r   <= '0;
      limit_r <= '0;
      ovf_r   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            idx_r   <= bus.init;
            limit_r <= bus.limit;
            ovf_r   <= 1'b0;
            state   <= (bus.init < bus.limit) ? S_RUN : S_DONE;
          end
        end
        S_RUN: begin
          if (!bus.hold) begin
            // a zero from INC means the index wrapped; flag it even if limit would also stop us
            if (bus.inc_d == '0) begin
              ovf_r <= 1'b1;
              state <= S_DONE;
            end else if (bus.inc_d >= limit_r) begin
              state <= S_DONE;
            end else begin
              idx_r <= bus.inc_d;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.inc_a = idx_r;
  assign bus.idx   = idx_r;
  assign bus.valid = (state == S_RUN) && !bus.hold;
  assign bus.busy  = (state == S_RUN);
  assign bus.done  = (state == S_DONE);
  assign bus.ovf   = ovf_r;

endmodule

// File: tb/tb_inc_loop_ctrl.sv
// Directed bench for inc_loop_ctrl with a scoreboard of expected iteration indices.
module tb_inc_loop_ctrl;
  import inc_loop_ctrl_pkg::*;

  logic clk;
  logic rst;
  logic       stub_en;
  logic [7:0] stub_at;

  int compared;
  int mismatched;

  logic [7:0] q[$];

  inc_loop_ctrl_if #(.DATAWIDTH(8)) bus ();

  inc_loop_ctrl #(.DATAWIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // INC model, optionally forced to wrap early at stub_at
  assign bus.inc_d = (stub_en && bus.inc_a == stub_at) ? 8'h00 : 8'(bus.inc_a + 8'd1);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_loop(input logic [7:0] i0, input logic [7:0] l0, input int exp_done,
                          input bit exp_ovf, input int hold_from, input int hold_len,
                          input bit poke);
    logic [7:0] v;
    logic [7:0] nxt;
    int         dk;
    bit         seen;
    q.delete();
    if (i0 < l0) begin
      v = i0;
      while (1) begin
        q.push_back(v);
        nxt = (stub_en && v == stub_at) ? 8'h00 : 8'(v + 8'd1);
        if (nxt == 8'h00 || nxt >= l0) break;
        v = nxt;
      end
    end
    @(negedge clk);
    bus.init  = i0;
    bus.limit = l0;
    bus.start = 1'b1;
    seen = 1'b0;
    dk   = 0;
    for (int k = 1; k <= 40 && !seen; k++) begin
      @(negedge clk);
      bus.start = poke && (k == 2);
      bus.hold  = (k >= hold_from) && (k < hold_from + hold_len);
      if (poke && k == 2) bus.init = 8'h55;
      #1;
      if (k == 1) check("ovf_cleared", {31'd0, bus.ovf}, 32'd0);
      if (bus.hold && bus.busy) begin
        check("stall_valid", {31'd0, bus.valid}, 32'd0);
        check("stall_idx", {24'd0, bus.idx}, {24'd0, q[0]});
      end
      if (bus.valid) begin
        check("valid_expected", {31'd0, q.size() > 0}, 32'd1);
        check("inc_a_eq_idx", {24'd0, bus.inc_a}, {24'd0, bus.idx});
        if (q.size() > 0) check("idx", {24'd0, bus.idx}, {24'd0, q.pop_front()});
      end
      if (bus.done) begin
        seen = 1'b1;
        dk   = k;
      end
    end
    check("done_seen", {31'd0, seen}, 32'd1);
    check("done_cycle", dk, exp_done);
    check("ovf_at_done", {31'd0, bus.ovf}, {31'd0, exp_ovf});
    check("busy_at_done", {31'd0, bus.busy}, 32'd0);
    check("iters_left", q.size(), 32'd0);
    bus.hold  = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    #1;
    check("done_one_cycle", {31'd0, bus.done}, 32'd0);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    stub_en    = 1'b0;
    stub_at    = 8'h00;
    bus.start  = 1'b0;
    bus.hold   = 1'b0;
    bus.init   = 8'h00;
    bus.limit  = 8'h00;
    rst        = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_idx", {24'd0, bus.idx}, 32'd0);
    check("rst_inc_a", {24'd0, bus.inc_a}, 32'd0);
    check("rst_flags", {28'd0, bus.valid, bus.busy, bus.done, bus.ovf}, 32'd0);

    // asynchronous reset during the third iteration of 2..8
    @(negedge clk);
    bus.init  = 8'd2;
    bus.limit = 8'd9;
    bus.start = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    #1;
    check("pre_rst_idx", {24'd0, bus.idx}, 32'd4);
    check("pre_rst_valid", {31'd0, bus.valid}, 32'd1);
    rst = 1'b1;
    #1;
    check("arst_idx", {24'd0, bus.idx}, 32'd0);
    check("arst_inc_a", {24'd0, bus.inc_a}, 32'd0);
    check("arst_flags", {28'd0, bus.valid, bus.busy, bus.done, bus.ovf}, 32'd0);
    check("arst_state", {30'd0, dut.state}, {30'd0, S_IDLE});
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      check("no_done_after_abort", {30'd0, bus.done, bus.busy}, 32'd0);
    end

    run_loop(8'd3, 8'd7, 5, 1'b0, 0, 0, 1'b0);
    run_loop(8'd5, 8'd5, 1, 1'b0, 0, 0, 1'b0);
    run_loop(8'd9, 8'd4, 1, 1'b0, 0, 0, 1'b0);
    run_loop(8'hFD, 8'hFF, 3, 1'b0, 0, 0, 1'b0);
    run_loop(8'hFE, 8'hFF, 2, 1'b0, 0, 0, 1'b0);

    stub_en = 1'b1;
    stub_at = 8'h10;
    run_loop(8'h0E, 8'h20, 4, 1'b1, 0, 0, 1'b0);
    stub_en = 1'b0;
    @(negedge clk);
    #1;
    check("ovf_sticky", {31'd0, bus.ovf}, 32'd1);
    run_loop(8'd3, 8'd4, 2, 1'b0, 0, 0, 1'b0);

    run_loop(8'd0, 8'd3, 6, 1'b0, 2, 2, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
